// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser, stability FSM and
// hold (long-press) timer per channel, with rise/fall/hold pulse outputs.
module debounce_multi #(
    parameter int              CH     = 4,
    parameter int              N      = 2,
    parameter int              HOLD_N = 4,
    parameter int              REPEAT = 0,
    parameter logic [CH-1:0]   INV    = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] hold
);

    localparam logic [0:0]        ST_STABLE   = 1'b0;
    localparam logic [0:0]        ST_WAIT     = 1'b1;
    localparam logic [N-1:0]      CNT_MAX     = {N{1'b1}};
    localparam logic [HOLD_N-1:0] HCNT_MAX    = {HOLD_N{1'b1}};
    localparam logic              ONE_SHOT    = (REPEAT == 0);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic              sync1_q;
        logic              sync2_q;
        logic              s_s;
        logic [0:0]        state_q;
        logic [0:0]        state_d;
        logic [N-1:0]      cnt_q;
        logic [N-1:0]      cnt_d;
        logic              out_q;
        logic              out_d;
        logic              rise_q;
        logic              rise_d;
        logic              fall_q;
        logic              fall_d;
        logic [HOLD_N-1:0] hcnt_q;
        logic [HOLD_N-1:0] hcnt_d;
        logic              done_q;
        logic              done_d;
        logic              hold_q;
        logic              hold_d;

        assign s_s = sync2_q ^ INV[i];

        // Stability FSM: a new level must persist through the full count to be accepted
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            case (state_q)
                ST_STABLE: begin
                    if (s_s != out_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = {N{1'b0}};
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_WAIT: begin
                    if (s_s == out_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = {N{1'b0}};
                    end else if (cnt_q == CNT_MAX) begin
                        out_d   = s_s;
                        state_d = ST_STABLE;
                        cnt_d   = {N{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = {N{1'b0}};
                end
            endcase
        end

        // Edge pulses and hold timer; gating on out_d keeps a hold pulse off the fall edge
        always_comb begin
            rise_d = ~out_q & out_d;
            fall_d = out_q & ~out_d;
            hold_d = out_q & out_d & (hcnt_q == HCNT_MAX) & ~done_q;
            if (out_q && out_d) begin
                hcnt_d = hcnt_q + 1'b1;
            end else begin
                hcnt_d = {HOLD_N{1'b0}};
            end
            if (!out_d) begin
                done_d = 1'b0;
            end else if (hold_d && ONE_SHOT) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end

        // Channel state registers; sync flops reset to the inactive raw level
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= INV[i];
                sync2_q <= INV[i];
                state_q <= ST_STABLE;
                cnt_q   <= {N{1'b0}};
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                hcnt_q  <= {HOLD_N{1'b0}};
                done_q  <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                sync1_q <= in[i];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                hcnt_q  <= hcnt_d;
                done_q  <= done_d;
                hold_q  <= hold_d;
            end
        end

        assign out[i]  = out_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
        assign hold[i] = hold_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi: one-shot instance (INV=0)
// and auto-repeat instance (INV=4'b1000) on a shared clock and reset.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_a, out_a, rise_a, fall_a, hold_a;
    logic [3:0] in_b, out_b, rise_b, fall_b, hold_b;
    logic [3:0] acc;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CH(4), .N(2), .HOLD_N(4), .REPEAT(0), .INV(4'b0000)) u_a (
        .clk(clk), .reset(reset), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .hold(hold_a)
    );

    debounce_multi #(.CH(4), .N(2), .HOLD_N(4), .REPEAT(1), .INV(4'b1000)) u_b (
        .clk(clk), .reset(reset), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .hold(hold_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset and idle
        reset = 1'b0;
        in_a  = 4'b1111;
        in_b  = 4'b1000;
        tick(3);
        chk("rst_out_a", out_a, 4'b0000);
        chk("rst_pulses_a", rise_a | fall_a | hold_a, 4'b0000);
        chk("rst_out_b", out_b, 4'b0000);
        chk("rst_pulses_b", rise_b | fall_b | hold_b, 4'b0000);
        reset = 1'b1;
        tick(6);
        chk("idle_edge5", out_a, 4'b0000);
        tick(1);
        chk("idle_out_edge6", out_a, 4'b1111);
        chk("idle_rise_edge6", rise_a, 4'b1111);
        chk("inactive_b", out_b, 4'b0000);
        acc = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            acc = acc | hold_a | rise_a;
        end
        chk("no_early_hold", acc, 4'b0000);
        tick(1);
        chk("hold_oneshot_16", hold_a, 4'b1111);
        acc = 4'b0000;
        for (int k = 17; k <= 40; k++) begin
            tick(1);
            acc = acc | hold_a;
        end
        chk("hold_oneshot_once", acc, 4'b0000);

        // 2. bounce then settle, falling then rising
        acc = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            in_a[0] = (k % 2 == 1);
            repeat (2) begin
                tick(1);
                acc = acc | rise_a | fall_a | (out_a ^ 4'b1111);
            end
        end
        chk("bounce_fall_quiet", acc, 4'b0000);
        in_a[0] = 1'b0;
        tick(6);
        chk("settle_fall_edge5", out_a, 4'b1111);
        tick(1);
        chk("settle_fall_out", out_a, 4'b1110);
        chk("settle_fall_pulse", fall_a, 4'b0001);
        acc = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            in_a[0] = (k % 2 == 0);
            repeat (2) begin
                tick(1);
                acc = acc | rise_a | fall_a | (out_a ^ 4'b1110);
            end
        end
        chk("bounce_rise_quiet", acc, 4'b0000);
        in_a[0] = 1'b1;
        tick(6);
        chk("settle_rise_edge5", out_a, 4'b1110);
        tick(1);
        chk("settle_rise_out", out_a, 4'b1111);
        chk("settle_rise_pulse", rise_a, 4'b0001);

        // 3. glitch boundary on channel 1 of B: 4 samples rejected, 5 accepted
        acc = 4'b0000;
        in_b[1] = 1'b1;
        repeat (4) begin
            tick(1);
            acc = acc | out_b | rise_b;
        end
        in_b[1] = 1'b0;
        repeat (10) begin
            tick(1);
            acc = acc | out_b | rise_b;
        end
        chk("glitch4_rejected", acc, 4'b0000);
        in_b[1] = 1'b1;
        tick(5);
        in_b[1] = 1'b0;
        tick(1);
        chk("glitch5_edge5", out_b, 4'b0000);
        tick(1);
        chk("glitch5_out", out_b, 4'b0010);
        chk("glitch5_rise", rise_b, 4'b0010);
        tick(4);
        chk("glitch5_still_high", out_b, 4'b0010);
        tick(1);
        chk("glitch5_fall_out", out_b, 4'b0000);
        chk("glitch5_fall", fall_b, 4'b0010);

        // 4. auto-repeat hold on channel 2 of B, release timed onto a counter wrap
        in_b[2] = 1'b1;
        tick(7);
        chk("rep_rise", rise_b, 4'b0100);
        for (int k = 1; k <= 41; k++) begin
            tick(1);
            chk($sformatf("rep_hold_%0d", k), hold_b, (k == 16 || k == 32) ? 4'b0100 : 4'b0000);
        end
        in_b[2] = 1'b0;
        for (int k = 42; k <= 47; k++) begin
            tick(1);
            chk($sformatf("rep_rel_hold_%0d", k), hold_b, 4'b0000);
        end
        tick(1);
        chk("rep_fall", fall_b, 4'b0100);
        chk("rep_no_hold_on_fall", hold_b, 4'b0000);
        acc = 4'b0000;
        repeat (20) begin
            tick(1);
            acc = acc | hold_b;
        end
        chk("rep_no_hold_after", acc, 4'b0000);

        // 5. polarity and independence: ch3 active-low, ch1/ch2 together, ch0 glitching
        in_b = 4'b0110;
        for (int k = 0; k < 6; k++) begin
            in_b[0] = (k % 2 == 1);
            tick(1);
        end
        chk("pol_edge5", out_b, 4'b0000);
        in_b[0] = 1'b0;
        tick(1);
        chk("pol_out", out_b, 4'b1110);
        chk("pol_rise_simul", rise_b, 4'b1110);
        chk("indep_a", out_a, 4'b1111);
        tick(10);
        chk("pol_ch0_quiet", out_b, 4'b1110);

        // 6. reset in the middle of a WAIT count
        in_a = 4'b1110;
        tick(8);
        chk("pre_rst_out", out_a, 4'b1110);
        in_a = 4'b1111;
        tick(5);
        reset = 1'b0;
        #1;
        chk("midrst_out_a", out_a, 4'b0000);
        chk("midrst_out_b", out_b, 4'b0000);
        reset = 1'b1;
        tick(6);
        chk("postrst_edge5", out_a, 4'b0000);
        tick(1);
        chk("postrst_out", out_a, 4'b1111);
        chk("postrst_rise", rise_a, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
